parity_frame_deser: RTL and testbench

//  Downstream consumer of the 1-bit parity-toggle stage's serial output. Collects

---
 rtl/parity_frame_deser_pkg.sv | 15 +
 rtl/parity_frame_deser_out_slot.sv | 57 +++++
 rtl/parity_frame_deser.sv | 93 +++++++++
 tb/tb_parity_frame_deser.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_deser_pkg.sv
// Shared definitions for the parity frame deserializer: FSM encoding,
// the output-slot payload type and the parity check helper.
package parity_frame_deser_pkg;

   localparam logic [0:0] S_DATA = 1'b0;
   localparam logic [0:0] S_PAR  = 1'b1;

   typedef logic [0:0] state_t;

   // True when the running XOR plus the final parity bit matches the requested sense.
   function automatic logic frame_parity_ok(input logic acc, input logic bit_val, input logic odd);
      return ((acc ^ bit_val) == odd);
   endfunction

endpackage

// File: rtl/parity_frame_deser_out_slot.sv
// One-deep valid/ready holding register for completed frames; frames arriving
// while the slot is occupied and not being drained are dropped and counted.
module deser_out_slot #(
   parameter int W    = 8,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [W-1:0]    load_word,
   input  logic            load_err,
   input  logic            ready,
   output logic [W-1:0]    word,
   output logic            valid,
   output logic            err,
   output logic [CNTW-1:0] drop_cnt
);

   logic [W-1:0]    word_reg;
   logic            valid_reg;
   logic            err_reg;
   logic [CNTW-1:0] drop_cnt_reg;
   logic            pop;
   logic            slot_free;

   assign pop       = valid_reg && ready;
   // A pop in the same cycle as a completing frame frees the slot for it.
   assign slot_free = !valid_reg || ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         word_reg     <= '0;
         valid_reg    <= 1'b0;
         err_reg      <= 1'b0;
         drop_cnt_reg <= '0;
      end else begin
         if (load && slot_free) begin
            word_reg  <= load_word;
            err_reg   <= load_err;
            valid_reg <= 1'b1;
         end else begin
            if (pop) begin
               valid_reg <= 1'b0;
            end
            if (load && (drop_cnt_reg != {CNTW{1'b1}})) begin
               drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
         end
      end
   end

   assign word     = word_reg;
   assign valid    = valid_reg;
   assign err      = err_reg;
   assign drop_cnt = drop_cnt_reg;

endmodule

// File: rtl/parity_frame_deser.sv
// Serial-to-parallel frame receiver: W data bits LSB first followed by one
// parity bit, delivered through a one-deep valid/ready output slot.
module parity_frame_deser
   import parity_frame_deser_pkg::*;
#(
   parameter int W    = 8,
   parameter int ODD  = 0,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            bit_in,
   input  logic            bit_valid,
   output logic [W-1:0]    word_out,
   output logic            word_valid,
   input  logic            word_ready,
   output logic            parity_err,
   output logic [CNTW-1:0] drop_cnt
);

   localparam int IW = $clog2(W);
   localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);
   localparam logic ODD_SENSE = (ODD != 0);

   state_t        state_reg;
   logic [IW-1:0] idx_reg;
   logic          acc_reg;
   logic [W-1:0]  shift_reg;
   logic          sample_data;
   logic          frame_done;
   logic          frame_err;

   assign sample_data = bit_valid && (state_reg == S_DATA);
   assign frame_done  = bit_valid && (state_reg == S_PAR);
   assign frame_err   = !frame_parity_ok(acc_reg, bit_in, ODD_SENSE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= S_DATA;
         idx_reg   <= '0;
         acc_reg   <= 1'b0;
      end else if (bit_valid) begin
         case (state_reg)
            S_DATA: begin
               acc_reg <= acc_reg ^ bit_in;
               if (idx_reg == IDX_LAST) begin
                  state_reg <= S_PAR;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= S_DATA;
               idx_reg   <= '0;
               acc_reg   <= 1'b0;
            end
         endcase
      end
   end

   // Each data bit is written only when the index addresses it, so the word
   // is complete and stable by the time the parity bit arrives.
   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_shift
         logic bit_q;
         always_ff @(posedge clk) begin
            if (!rst) begin
               bit_q <= 1'b0;
            end else if (sample_data && (idx_reg == IW'(gi))) begin
               bit_q <= bit_in;
            end
         end
         assign shift_reg[gi] = bit_q;
      end
   endgenerate

   deser_out_slot #(
      .W    (W),
      .CNTW (CNTW)
   ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (frame_done),
      .load_word (shift_reg),
      .load_err  (frame_err),
      .ready     (word_ready),
      .word      (word_out),
      .valid     (word_valid),
      .err       (parity_err),
      .drop_cnt  (drop_cnt)
   );

endmodule

// File: tb/tb_parity_frame_deser.sv
// Directed self-checking bench for parity_frame_deser (W=8, even parity).
module tb_parity_frame_deser;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       word_ready = 1'b0;
   logic [7:0] word_out;
   logic       word_valid;
   logic       parity_err;
   logic [7:0] drop_cnt;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   always #5 clk = ~clk;

   parity_frame_deser #(.W(8), .ODD(0), .CNTW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .parity_err (parity_err),
      .drop_cnt   (drop_cnt)
   );

   task automatic send_bit(input logic b, input bit gap);
      @(negedge clk);
      bit_in    = b;
      bit_valid = 1'b1;
      @(posedge clk);
      if (gap) begin
         @(negedge clk);
         bit_valid = 1'b0;
         @(posedge clk);
      end
   endtask

   task automatic send_data(input logic [7:0] d, input int nbits, input bit gap);
      for (int i = 0; i < nbits; i++) send_bit(d[i], gap);
   endtask

   // Full frame; returns at the negedge following the parity-bit sample edge.
   task automatic send_frame(input logic [7:0] d, input logic par, input bit gap);
      send_data(d, 8, gap);
      send_bit(par, gap);
      if (!gap) begin
         @(negedge clk);
         bit_valid = 1'b0;
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic flush_slot();
      @(negedge clk);
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      assert_cnt++;
      if ({word_out, word_valid, parity_err, drop_cnt} !== 18'd0) begin
         fail_cnt++;
         $display("FAIL reset_state: out=%h v=%b e=%b drop=%0d, required all zero",
                  word_out, word_valid, parity_err, drop_cnt);
      end
      rst = 1'b1;
      $display("reset: out=%h v=%b e=%b drop=%0d", word_out, word_valid, parity_err, drop_cnt);
   endtask

   task automatic test_basic();
      word_ready = 1'b1;
      send_data(8'hA5, 8, 1'b0);
      @(negedge clk);
      assert_cnt++;
      if (word_valid !== 1'b0) begin
         fail_cnt++;
         $display("FAIL basic_early_valid: valid=%b required 0 before parity", word_valid);
      end
      bit_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bit_valid = 1'b0;
      assert_cnt++;
      if (word_valid !== 1'b1 || word_out !== 8'hA5 || parity_err !== 1'b0) begin
         fail_cnt++;
         $display("FAIL basic_word: v=%b out=%h e=%b, required v=1 out=a5 e=0",
                  word_valid, word_out, parity_err);
      end
      $display("frame 0xa5: v=%b out=%h e=%b", word_valid, word_out, parity_err);
      @(negedge clk);
      assert_cnt++;
      if (word_valid !== 1'b0) begin
         fail_cnt++;
         $display("FAIL basic_pop: valid=%b required 0 after accept", word_valid);
      end
   endtask

   task automatic test_parity_err();
      word_ready = 1'b1;
      send_frame(8'h01, 1'b0, 1'b0);
      assert_cnt++;
      if (word_valid !== 1'b1 || word_out !== 8'h01 || parity_err !== 1'b1 || drop_cnt !== 8'd0) begin
         fail_cnt++;
         $display("FAIL parity_err: v=%b out=%h e=%b drop=%0d, required v=1 out=01 e=1 drop=0",
                  word_valid, word_out, parity_err, drop_cnt);
      end
      $display("frame 0x01 bad parity: v=%b out=%h e=%b drop=%0d", word_valid, word_out, parity_err, drop_cnt);
      word_ready = 1'b0;
   endtask

   task automatic test_drop();
      flush_slot();
      send_frame(8'h11, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0);
      assert_cnt++;
      if (word_valid !== 1'b1 || word_out !== 8'h11 || drop_cnt !== 8'd1) begin
         fail_cnt++;
         $display("FAIL drop_hold: v=%b out=%h drop=%0d, required v=1 out=11 drop=1",
                  word_valid, word_out, drop_cnt);
      end
      $display("frames 0x11,0x22 slot full: out=%h drop=%0d", word_out, drop_cnt);
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
      assert_cnt++;
      if (word_valid !== 1'b0) begin
         fail_cnt++;
         $display("FAIL drop_accept: valid=%b required 0 after accept", word_valid);
      end
   endtask

   task automatic test_same_cycle_pop();
      send_frame(8'h33, 1'b0, 1'b0);
      send_data(8'h44, 8, 1'b0);
      @(negedge clk);
      bit_in     = 1'b0;
      word_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bit_valid  = 1'b0;
      word_ready = 1'b0;
      assert_cnt++;
      if (word_valid !== 1'b1 || word_out !== 8'h44 || drop_cnt !== 8'd1) begin
         fail_cnt++;
         $display("FAIL same_cycle_pop: v=%b out=%h drop=%0d, required v=1 out=44 drop=1",
                  word_valid, word_out, drop_cnt);
      end
      $display("frame 0x44 with same-cycle pop: out=%h drop=%0d", word_out, drop_cnt);
   endtask

   task automatic test_gap_and_reset();
      flush_slot();
      send_frame(8'h0F, 1'b0, 1'b1);
      assert_cnt++;
      if (word_valid !== 1'b1 || word_out !== 8'h0F || parity_err !== 1'b0) begin
         fail_cnt++;
         $display("FAIL gap_frame: v=%b out=%h e=%b, required v=1 out=0f e=0",
                  word_valid, word_out, parity_err);
      end
      $display("frame 0x0f with gaps: v=%b out=%h e=%b", word_valid, word_out, parity_err);
      send_data(8'hFF, 4, 1'b0);
      @(negedge clk);
      bit_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      assert_cnt++;
      if ({word_out, word_valid, parity_err, drop_cnt} !== 18'd0) begin
         fail_cnt++;
         $display("FAIL midframe_reset: out=%h v=%b e=%b drop=%0d, required all zero",
                  word_out, word_valid, parity_err, drop_cnt);
      end
      rst = 1'b1;
      send_frame(8'hC3, 1'b0, 1'b0);
      assert_cnt++;
      if (word_valid !== 1'b1 || word_out !== 8'hC3 || parity_err !== 1'b0 || drop_cnt !== 8'd0) begin
         fail_cnt++;
         $display("FAIL post_reset_frame: v=%b out=%h e=%b drop=%0d, required v=1 out=c3 e=0 drop=0",
                  word_valid, word_out, parity_err, drop_cnt);
      end
      $display("frame 0xc3 after reset: v=%b out=%h e=%b", word_valid, word_out, parity_err);
   endtask

   task automatic test_saturation();
      flush_slot();
      for (int n = 0; n < 300; n++) begin
         send_frame((n == 0) ? 8'h5A : 8'(n), 1'b0, 1'b0);
         if (n == 100) begin
            assert_cnt++;
            if (drop_cnt !== 8'd100) begin
               fail_cnt++;
               $display("FAIL drop_count_mid: drop=%0d required 100", drop_cnt);
            end
         end
      end
      assert_cnt++;
      if (drop_cnt !== 8'hFF || word_out !== 8'h5A || word_valid !== 1'b1) begin
         fail_cnt++;
         $display("FAIL drop_saturate: drop=%h out=%h v=%b, required drop=ff out=5a v=1",
                  drop_cnt, word_out, word_valid);
      end
      $display("300 frames slot full: drop=%h out=%h", drop_cnt, word_out);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity_err();
      test_drop();
      test_same_cycle_pop();
      test_gap_and_reset();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
